// File: rtl/sigdecode_h_stream.sv
// ML-DSA hint (h) decoder: validates the encoded header, expands each hint
// polynomial into a bitmap and streams it to memory COEFFS_PER_WR coefficients per word.
package sigdecode_h_stream_pkg;
  localparam int ABR_MEM_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;
endpackage

module sigdecode_h_stream
  import sigdecode_h_stream_pkg::*;
#(
  parameter int REG_SIZE      = 24,
  parameter int MLDSA_OMEGA   = 75,
  parameter int MLDSA_K       = 8,
  parameter int MLDSA_N       = 256,
  parameter int COEFFS_PER_WR = 4,
  parameter int HINTS_PER_CYC = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   zeroize,
  input  logic [(MLDSA_OMEGA+MLDSA_K)*8-1:0]     encoded_h_i,
  input  logic                                   sigdecode_h_enable,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0]          dest_base_addr,
  input  logic                                   mem_wr_ready,
  output mem_if_t                                mem_wr_req,
  output logic [COEFFS_PER_WR*REG_SIZE-1:0]      mem_wr_data,
  output logic                                   sigdecode_h_done,
  output logic                                   sigdecode_h_error
);

  localparam int NB     = MLDSA_OMEGA + MLDSA_K;
  localparam int PTR_W  = $clog2(MLDSA_OMEGA + 1);
  localparam int POLY_W = (MLDSA_K > 1) ? $clog2(MLDSA_K) : 1;
  localparam int WORDS  = MLDSA_N / COEFFS_PER_WR;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BM_W   = $clog2(MLDSA_N);
  localparam int LANE_W = $clog2(COEFFS_PER_WR);
  localparam int ADDR_W = ABR_MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BUILD,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [POLY_W-1:0]   poly_idx_q;
  logic [WORD_W-1:0]   word_idx_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [MLDSA_N-1:0]  bitmap_q;
  logic [7:0]          prev_byte_q;
  logic                first_hint_q;
  logic                error_q;

  // Byte view of the encoded field; the last K bytes are the cumulative counts S[p].
  logic [7:0] hbyte [NB];
  logic [7:0] s_hdr [MLDSA_K];

  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign hbyte[gi] = encoded_h_i[gi*8 +: 8];
  end

  for (genvar gk = 0; gk < MLDSA_K; gk++) begin : g_hdr
    assign s_hdr[gk] = hbyte[MLDSA_OMEGA + gk];
  end

  logic [7:0] s_cur, s_nxt;
  logic       last_poly, next_empty, last_word, in_write;

  assign s_cur      = s_hdr[poly_idx_q];
  assign s_nxt      = s_hdr[poly_idx_q + 1'b1];
  assign last_poly  = (poly_idx_q == POLY_W'(MLDSA_K - 1));
  assign next_empty = (s_nxt == s_cur);
  assign last_word  = (word_idx_q == WORD_W'(WORDS - 1));
  assign in_write   = (state_q == S_WRITE);

  // Whole-header validation, evaluated in the single CHECK cycle.
  logic hdr_err;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hdr_err = 1'b0;
    for (int k = 0; k < MLDSA_K; k++) begin
      if (s_hdr[k] > 8'(MLDSA_OMEGA)) hdr_err = 1'b1;
    end
    for (int k = 1; k < MLDSA_K; k++) begin
      if (s_hdr[k] < s_hdr[k-1]) hdr_err = 1'b1;
    end
    for (int i = 0; i < MLDSA_OMEGA; i++) begin
      if ((8'(i) >= s_hdr[MLDSA_K-1]) && (hbyte[i] != 8'd0)) hdr_err = 1'b1;
    end
  end

  // BUILD datapath: consume up to HINTS_PER_CYC bytes, chaining the ordering check across lanes.
  logic [PTR_W-1:0]   remaining, consumed, byte_idx, rd_ptr_build;
  logic [7:0]         cur_b, chain_prev;
  logic               chain_first, build_viol, build_last;
  logic [MLDSA_N-1:0] bm_set;

  always_comb begin
    remaining   = PTR_W'(s_cur) - rd_ptr_q;
    consumed    = '0;
    byte_idx    = '0;
    cur_b       = '0;
    chain_prev  = prev_byte_q;
    chain_first = first_hint_q;
    build_viol  = 1'b0;
    bm_set      = '0;
    for (int k = 0; k < HINTS_PER_CYC; k++) begin
      if (PTR_W'(k) < remaining) begin
        byte_idx = rd_ptr_q + PTR_W'(k);
        cur_b    = hbyte[byte_idx];
        if (!chain_first && (cur_b <= chain_prev)) build_viol = 1'b1;
        bm_set[BM_W'(cur_b)] = 1'b1;
        chain_prev  = cur_b;
        chain_first = 1'b0;
        consumed    = consumed + 1'b1;
      end
    end
    rd_ptr_build = rd_ptr_q + consumed;
    build_last   = (rd_ptr_build == PTR_W'(s_cur));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sigdecode_h_enable) state_d = S_CHECK;
      S_CHECK: begin
        if (hdr_err)              state_d = S_DONE;
        else if (s_cur == 8'd0)   state_d = S_WRITE;
        else                      state_d = S_BUILD;
      end
      S_BUILD: begin
        if (build_viol)           state_d = S_DONE;
        else if (build_last)      state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_wr_ready && last_word) begin
          if (last_poly)          state_d = S_DONE;
          else if (next_empty)    state_d = S_WRITE;
          else                    state_d = S_BUILD;
        end
      end
      S_DONE:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || zeroize) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      base_q       <= '0;
      poly_idx_q   <= '0;
      word_idx_q   <= '0;
      rd_ptr_q     <= '0;
      bitmap_q     <= '0;
      prev_byte_q  <= '0;
      first_hint_q <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sigdecode_h_enable) begin
            base_q       <= dest_base_addr;
            error_q      <= 1'b0;
            poly_idx_q   <= '0;
            word_idx_q   <= '0;
            rd_ptr_q     <= '0;
            bitmap_q     <= '0;
            first_hint_q <= 1'b1;
          end
        end
        S_CHECK: begin
          if (hdr_err) error_q <= 1'b1;
        end
        S_BUILD: begin
          bitmap_q     <= bitmap_q | bm_set;
          rd_ptr_q     <= rd_ptr_build;
          prev_byte_q  <= chain_prev;
          first_hint_q <= chain_first;
          if (build_viol) error_q <= 1'b1;
        end
        S_WRITE: begin
          if (mem_wr_ready) begin
            if (last_word) begin
              // Poly finished: rd_ptr jumps to S[p] so empty polys need no BUILD cycle.
              word_idx_q   <= '0;
              bitmap_q     <= '0;
              rd_ptr_q     <= PTR_W'(s_cur);
              poly_idx_q   <= poly_idx_q + 1'b1;
              first_hint_q <= 1'b1;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Write port: address and data derive only from registers, so they hold while stalled.
  logic [BM_W-1:0]          word_lsb;
  logic [COEFFS_PER_WR-1:0] word_bits;
  logic [ADDR_W-1:0]        wr_addr;

  assign word_lsb  = BM_W'(word_idx_q) << LANE_W;
  assign word_bits = bitmap_q[word_lsb +: COEFFS_PER_WR];
  assign wr_addr   = base_q + ADDR_W'(poly_idx_q) * ADDR_W'(WORDS) + ADDR_W'(word_idx_q);

  for (genvar gj = 0; gj < COEFFS_PER_WR; gj++) begin : g_lanes
    assign mem_wr_data[gj*REG_SIZE +: REG_SIZE] = in_write ? REG_SIZE'(word_bits[gj]) : '0;
  end

  always_comb begin
    mem_wr_req          = '0;
    mem_wr_req.rd_wr_en = RW_IDLE;
    if (in_write) begin
      mem_wr_req.rd_wr_en = RW_WRITE;
      mem_wr_req.addr     = wr_addr;
    end
  end

  assign sigdecode_h_done  = (state_q == S_DONE);
  assign sigdecode_h_error = error_q;

endmodule
